// File: rtl/regwb_queue.sv
// Write-back queue in front of the 16x16 register file: buffers results, issues one
// write per cycle when the port is free, and forwards pending values to decode readers.
module regwb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [REG_W-1:0]             enq_reg,
  input  logic [DATA_W-1:0]            enq_data,
  input  logic                         drain_en,
  output logic                         WriteReg,
  output logic [REG_W-1:0]             DstReg,
  output logic [DATA_W-1:0]            DstData,
  input  logic [REG_W-1:0]             SrcReg1,
  input  logic [REG_W-1:0]             SrcReg2,
  output logic                         fwd1_hit,
  output logic                         fwd2_hit,
  output logic [DATA_W-1:0]            fwd1_data,
  output logic [DATA_W-1:0]            fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [REG_W-1:0]  mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign enq_ready = (count_q < CNT_W'(DEPTH));
  assign push      = enq_valid && enq_ready && (enq_reg != '0);
  assign pop       = WriteReg;

  assign WriteReg  = (count_q != '0) && drain_en;
  assign DstReg    = (count_q != '0) ? mem_reg_q[head_q]  : '0;
  assign DstData   = (count_q != '0) ? mem_data_q[head_q] : '0;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q;
    if (pop) begin
      head_d        = head_q + PTR_W'(1);
      vld_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d        = tail_q + PTR_W'(1);
      vld_d[tail_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg_q[tail_q]  <= enq_reg;
      mem_data_q[tail_q] <= enq_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending value.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_W-1:0] src);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (src != '0) && (mem_reg_q[idx] == src))
        res = {1'b1, mem_data_q[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = fwd_lookup(SrcReg1);
    {fwd2_hit, fwd2_data} = fwd_lookup(SrcReg2);
  end

endmodule

// File: tb/tb_regwb_queue.sv
// Bench for regwb_queue: directed scenarios plus random traffic, scored against a
// queue-based model of pending writes and an expected-write scoreboard.
module tb_regwb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq_valid = 1'b0;
  logic              enq_ready;
  logic [REG_W-1:0]  enq_reg = '0;
  logic [DATA_W-1:0] enq_data = '0;
  logic              drain_en = 1'b1;
  logic              WriteReg;
  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic [REG_W-1:0]  SrcReg1 = '0;
  logic [REG_W-1:0]  SrcReg2 = '0;
  logic              fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;
  logic [CNT_W-1:0]  count;

  regwb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_reg(enq_reg), .enq_data(enq_data),
    .drain_en(drain_en), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              model_q[$];
  ent_t              exp_q[$];
  logic [DATA_W-1:0] rf [16];
  int                tests = 0;
  int                fails = 0;
  bit                checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W:0] model_fwd(input logic [REG_W-1:0] s);
    if (s == 0) return '0;
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].r == s) return {1'b1, model_q[i].d};
    return '0;
  endfunction

  // Reference model: pending writes as a plain FIFO list
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      automatic int sz = model_q.size();
      automatic ent_t e;
      if (drain_en && sz > 0) void'(model_q.pop_front());
      if (enq_valid && sz < DEPTH && enq_reg != 0) begin
        e.r = enq_reg;
        e.d = enq_data;
        model_q.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compare outputs against the model away from the active edge
  always @(negedge clk) begin
    if (checking && rst) begin
      automatic logic [DATA_W:0] f1 = model_fwd(SrcReg1);
      automatic logic [DATA_W:0] f2 = model_fwd(SrcReg2);
      automatic ent_t e;
      chk("count", 32'(count), 32'(model_q.size()));
      chk("enq_ready", 32'(enq_ready), 32'(model_q.size() < DEPTH));
      chk("WriteReg", 32'(WriteReg), 32'(model_q.size() > 0 && drain_en));
      chk("fwd1", 32'({fwd1_hit, fwd1_data}), 32'(f1));
      chk("fwd2", 32'({fwd2_hit, fwd2_data}), 32'(f2));
      if (model_q.size() == 0) begin
        chk("DstReg_idle", 32'(DstReg), 0);
        chk("DstData_idle", 32'(DstData), 0);
      end
      if (WriteReg) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("DstReg", 32'(DstReg), 32'(e.r));
          chk("DstData", 32'(DstData), 32'(e.d));
        end
        rf[DstReg] = DstData;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    bit acc = 0;
    int n = 0;
    enq_valid = 1'b1;
    enq_reg   = r;
    enq_data  = d;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = enq_ready;
      step();
      n++;
    end
    if (!acc) chk("enq_timeout", 0, 1);
    enq_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    checking = 1;
    step();

    // Idle after reset
    SrcReg1 = 4'd3;
    repeat (2) step();
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_WriteReg", 32'(WriteReg), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 0);
    step();

    // Single write, next-cycle issue
    enq(4'd3, 16'h1234);
    @(negedge clk);
    chk("t2_WriteReg", 32'(WriteReg), 1);
    chk("t2_DstReg", 32'(DstReg), 3);
    chk("t2_DstData", 32'(DstData), 32'h1234);
    step();
    @(negedge clk);
    chk("t2_count", 32'(count), 0);
    step();
    chk("t2_rf3", 32'(rf[3]), 32'h1234);

    // Fill with drain withheld, check youngest forwarding
    drain_en = 1'b0;
    SrcReg1 = 4'd5;
    SrcReg2 = 4'd7;
    enq(4'd5, 16'h0001);
    enq(4'd5, 16'h0002);
    enq(4'd7, 16'h00AA);
    enq(4'd9, 16'h0BEE);
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(enq_ready), 0);
    chk("full_fwd1", 32'({fwd1_hit, fwd1_data}), 32'h1_0002);
    chk("full_fwd2", 32'({fwd2_hit, fwd2_data}), 32'h1_00AA);
    step();
    fork
      enq(4'd2, 16'hFFFF);
      begin
        repeat (3) step();
        drain_en = 1'b1;
      end
    join
    repeat (8) step();
    chk("order_rf5", 32'(rf[5]), 32'h0002);
    chk("order_rf7", 32'(rf[7]), 32'h00AA);
    chk("order_rf9", 32'(rf[9]), 32'h0BEE);
    chk("order_rf2", 32'(rf[2]), 32'hFFFF);

    // r0 write is swallowed
    SrcReg1 = 4'd0;
    enq(4'd0, 16'hDEAD);
    @(negedge clk);
    chk("r0_count", 32'(count), 0);
    chk("r0_WriteReg", 32'(WriteReg), 0);
    chk("r0_fwd1_hit", 32'(fwd1_hit), 0);
    step();

    // Asynchronous reset mid-cycle with pending entries
    drain_en = 1'b0;
    SrcReg1 = 4'd1;
    enq(4'd1, 16'h1111);
    enq(4'd2, 16'h2222);
    enq(4'd3, 16'h3333);
    drain_en = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_WriteReg", 32'(WriteReg), 0);
    chk("arst_fwd1_hit", 32'(fwd1_hit), 0);
    #5 rst = 1'b1;
    step();
    repeat (4) step();
    chk("arst_rf1", 32'(rf[1]), 0);

    // Wrap-around: consecutive enqueue/drain pairs
    for (int i = 0; i < 9; i++) enq(4'((i % 7) + 1), 16'($urandom));
    repeat (3) step();
    chk("wrap_drained", 32'(exp_q.size()), 0);

    // Random traffic; producer holds its request until accepted
    for (int i = 0; i < 400; i++) begin
      bit acc;
      @(negedge clk);
      acc = enq_valid && enq_ready;
      step();
      if (!enq_valid || acc) begin
        enq_valid = ($urandom_range(0, 99) < 60);
        enq_reg   = 4'($urandom_range(0, 7));
        enq_data  = 16'($urandom);
      end
      drain_en = ($urandom_range(0, 99) < 55);
      SrcReg1  = 4'($urandom_range(0, 7));
      SrcReg2  = 4'($urandom_range(0, 7));
    end
    enq_valid = 1'b0;
    drain_en  = 1'b1;
    repeat (8) step();
    chk("final_drained", 32'(exp_q.size()), 0);
    chk("final_count", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
